// File: rtl/mips32_pkg.sv
// mips32_pkg: shared widths and register index constants for the MIPS32 datapath
package mips32_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 5;
    localparam int NUM_REGS       = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [ADDR_WIDTH-1:0] ZERO = 5'd0;
    localparam logic [ADDR_WIDTH-1:0] SP   = 5'd29;
    localparam logic [ADDR_WIDTH-1:0] RA   = 5'd31;
endpackage

// File: rtl/register_mips32.sv
// register_mips32: 2-read/1-write register file with per-byte write enables and hard-wired R0
module register_mips32
    import mips32_pkg::*;
#(
    parameter int DATA_WIDTH = mips32_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips32_pkg::ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   Rs_addr,
    input  logic [ADDR_WIDTH-1:0]   Rt_addr,
    input  logic [ADDR_WIDTH-1:0]   Rd_addr,
    input  logic [DATA_WIDTH-1:0]   Rd_in,
    input  logic [DATA_WIDTH/8-1:0] Rd_Byte_w_en,
    output logic [DATA_WIDTH-1:0]   Rs_out,
    output logic [DATA_WIDTH-1:0]   Rt_out
);
    localparam int REGS  = 2**ADDR_WIDTH;
    localparam int BYTES = DATA_WIDTH/8;

    logic [DATA_WIDTH-1:0] regs_q [REGS];
    logic [DATA_WIDTH-1:0] regs_d [REGS];
    logic [DATA_WIDTH-1:0] merged;

    // Each lane takes new data when enabled, otherwise keeps the target's current byte
    for (genvar b = 0; b < BYTES; b++) begin : g_lane
        assign merged[b*8 +: 8] = Rd_Byte_w_en[b] ? Rd_in[b*8 +: 8] : regs_q[Rd_addr][b*8 +: 8];
    end

    always_comb begin
        regs_d = regs_q;
        if (Rd_addr != '0)
            regs_d[Rd_addr] = merged;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    // R0 is never written, but gating the read keeps it zero even before reset
    assign Rs_out = (Rs_addr == '0) ? '0 : regs_q[Rs_addr];
    assign Rt_out = (Rt_addr == '0) ? '0 : regs_q[Rt_addr];
endmodule

// File: tb/tb_register_mips32.sv
// tb_register_mips32: directed self-checking bench for register_mips32
module tb_register_mips32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  Rs_addr = '0;
    logic [4:0]  Rt_addr = '0;
    logic [4:0]  Rd_addr = '0;
    logic [31:0] Rd_in = '0;
    logic [3:0]  Rd_Byte_w_en = '0;
    logic [31:0] Rs_out;
    logic [31:0] Rt_out;
    int checks = 0;
    int errors = 0;

    register_mips32 dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_addr(Rs_addr), .Rt_addr(Rt_addr), .Rd_addr(Rd_addr),
        .Rd_in(Rd_in), .Rd_Byte_w_en(Rd_Byte_w_en),
        .Rs_out(Rs_out), .Rt_out(Rt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] s, input logic [31:0] es,
                      input logic [4:0] t, input logic [31:0] et);
        Rs_addr = s;
        Rt_addr = t;
        #1;
        chk({tag, "_rs"}, Rs_out, es);
        chk({tag, "_rt"}, Rt_out, et);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] en);
        @(negedge clk);
        Rd_addr = a;
        Rd_in = d;
        Rd_Byte_w_en = en;
        @(posedge clk);
        #1;
        Rd_Byte_w_en = '0;
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        Rd_addr = 5'd9;
        Rd_in = 32'hFFFF_FFFF;
        Rd_Byte_w_en = 4'hF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        Rd_Byte_w_en = '0;
        for (int i = 0; i < 32; i++)
            rd("reset_sweep", 5'(i), 32'h0, 5'(31 - i), 32'h0);

        wr(5'd1, 32'h0000_0048, 4'hF);
        wr(5'd2, 32'h1234_5678, 4'hF);
        rd("word_dual", 5'd1, 32'h0000_0048, 5'd2, 32'h1234_5678);

        wr(5'd2, 32'h0000_007F, 4'b1110);
        rd("en_1110", 5'd2, 32'h0000_0078, 5'd1, 32'h0000_0048);

        wr(5'd2, 32'hFFFF_FFFF, 4'b0000);
        rd("en_0000", 5'd2, 32'h0000_0078, 5'd2, 32'h0000_0078);

        wr(5'd3, 32'hAABB_CCDD, 4'b0101);
        rd("en_0101", 5'd3, 32'h00BB_00DD, 5'd2, 32'h0000_0078);

        wr(5'd4, 32'hAABB_CCDD, 4'b1000);
        rd("en_1000", 5'd4, 32'hAA00_0000, 5'd3, 32'h00BB_00DD);

        wr(5'd0, 32'hFFFF_FFFF, 4'hF);
        rd("r0_protect", 5'd0, 32'h0, 5'd1, 32'h0000_0048);

        wr(5'd31, 32'hCAFE_F00D, 4'hF);
        rd("r31", 5'd31, 32'hCAFE_F00D, 5'd31, 32'hCAFE_F00D);

        wr(5'd5, 32'h1111_1111, 4'hF);
        @(negedge clk);
        Rs_addr = 5'd5;
        Rt_addr = 5'd5;
        Rd_addr = 5'd5;
        Rd_in = 32'h2222_2222;
        Rd_Byte_w_en = 4'hF;
        #1;
        chk("rdw_before", Rs_out, 32'h1111_1111);
        @(posedge clk);
        #1;
        Rd_Byte_w_en = '0;
        chk("rdw_after_rs", Rs_out, 32'h2222_2222);
        chk("rdw_after_rt", Rt_out, 32'h2222_2222);

        wr(5'd7, 32'h0102_0304, 4'hF);
        rd("r7_pre", 5'd7, 32'h0102_0304, 5'd3, 32'h00BB_00DD);
        @(negedge clk);
        rst_n = 1'b0;
        Rd_addr = 5'd7;
        Rd_in = 32'hDEAD_BEEF;
        Rd_Byte_w_en = 4'hF;
        @(posedge clk);
        #1;
        rd("rst_prio", 5'd7, 32'h0, 5'd31, 32'h0);
        rd("rst_clear", 5'd5, 32'h0, 5'd2, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        Rd_addr = 5'd6;
        Rd_in = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        Rd_Byte_w_en = '0;
        rd("first_write", 5'd6, 32'h0BAD_F00D, 5'd7, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
